// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (33-edge start-to-result latency).
// Define MULDIV_DIV_EN to compile in the DIV/DIVU datapath; otherwise divide starts are ignored.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic        neg_q, neg_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] prod_res;

`ifdef MULDIV_DIV_EN
    logic        div_q, div_d;
    logic        rem_neg_q, rem_neg_d;
    logic        b_zero_q, b_zero_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [32:0] rem_sub;
`endif

    // op[0]=0 selects the signed variants (MULT, DIV)
    assign op_signed = ~op[0];
    assign a_mag     = (op_signed && a[31]) ? (~a + 32'd1) : a;
    assign b_mag     = (op_signed && b[31]) ? (~b + 32'd1) : b;

`ifdef MULDIV_DIV_EN
    assign accept = (state_q == S_IDLE) && start;
`else
    assign accept = (state_q == S_IDLE) && start && !op[1];
`endif

    // Multiply: acc_lo holds the remaining multiplier bits, acc_hi the running upper partial product.
    assign mul_sum  = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? b_mag_q : 32'd0)};
    assign prod_res = neg_q ? (~{acc_hi_q, acc_lo_q} + 64'd1) : {acc_hi_q, acc_lo_q};

`ifdef MULDIV_DIV_EN
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
    assign rem_sh  = {acc_hi_q, acc_lo_q[31]};
    assign rem_ge  = (rem_sh >= {1'b0, b_mag_q});
    assign rem_sub = rem_sh - {1'b0, b_mag_q};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_DIV_EN
        div_d     = div_q;
        rem_neg_d = rem_neg_q;
        b_zero_d  = b_zero_q;
        a_raw_d   = a_raw_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_RUN;
                    cnt_d    = 5'd0;
                    acc_hi_d = 32'd0;
                    acc_lo_d = a_mag;
                    b_mag_d  = b_mag;
                    neg_d    = op_signed & (a[31] ^ b[31]);
`ifdef MULDIV_DIV_EN
                    div_d     = op[1];
                    rem_neg_d = op_signed & a[31];
                    b_zero_d  = (b == 32'd0);
                    a_raw_d   = a;
`endif
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIN;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    acc_hi_d = rem_ge ? rem_sub[31:0] : rem_sh[31:0];
                    acc_lo_d = {acc_lo_q[30:0], rem_ge};
                end else
`endif
                begin
                    acc_hi_d = mul_sum[32:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    if (b_zero_q) begin
                        hi_d = a_raw_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        lo_d = neg_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
                        hi_d = rem_neg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
                    end
                end else
`endif
                begin
                    hi_d = prod_res[63:32];
                    lo_d = prod_res[31:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            b_mag_q  <= 32'd0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
`ifdef MULDIV_DIV_EN
            div_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_raw_q   <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULDIV_DIV_EN
            div_q     <= div_d;
            rem_neg_q <= rem_neg_d;
            b_zero_q  <= b_zero_d;
            a_raw_q   <= a_raw_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected {hi,lo}, a monitor pops on each done pulse.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_e;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 hi=%08h lo=%08h expected no completion", hi, lo);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_hi", hi, mon_e[63:32]);
                check("result_lo", lo, mon_e[31:0]);
                $display("txn done hi=%08h lo=%08h (expected %08h %08h)", hi, lo, mon_e[63:32], mon_e[31:0]);
            end
        end
    end

    // Caller is at a negedge; issues one start and records the expected result.
    task automatic launch(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [63:0] exp);
        op    = op_v;
        a     = a_v;
        b     = b_v;
        start = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for done (bounded), checking latency/busy length; optionally injects a start and
    // HI/LO writes while busy and checks they are ignored. Returns at the done-cycle negedge.
    task automatic wait_done(input string name, input int inject_at,
                             input logic [31:0] held_hi, input logic [31:0] held_lo);
        int cyc  = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        while (cyc < 40 && !seen) begin
            @(negedge clk);
            if (inject_at >= 0 && cyc == inject_at + 1) begin
                start = 1'b0;
                wr_hi = 1'b0;
                wr_lo = 1'b0;
                check({name, "_hold_hi"}, hi, held_hi);
                check({name, "_hold_lo"}, lo, held_lo);
            end
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (inject_at >= 0 && cyc == inject_at) begin
                    start = 1'b1;
                    op    = OP_MULTU;
                    a     = 32'd2;
                    b     = 32'd2;
                    wr_hi = 1'b1;
                    wr_lo = 1'b1;
                    wdata = 32'hDEAD_BEEF;
                end
                @(posedge clk);
                cyc++;
            end
        end
        check({name, "_latency"}, cyc, 32'd33);
        check({name, "_busy_cycles"}, bcnt, 32'd33);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit busy_seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0;

        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        wait_done("multu_max", -1, 32'd0, 32'd0);

        // Back-to-back: launched in the done cycle.
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        wait_done("mult_neg_b2b", -1, 32'd0, 32'd0);

        @(negedge clk);
        launch(OP_MULTU, 32'd7, 32'd6, {32'd0, 32'd42});
        wait_done("multu_ignore_busy", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        @(negedge clk);
        wr_hi = 1'b1;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1 wr_hi = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo_kept", lo, 32'd42);

        @(negedge clk);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 begin
            wr_hi = 1'b0;
            wr_lo = 1'b0;
        end
        @(negedge clk);
        check("mthi_mtlo_hi", hi, 32'hA5A5_A5A5);
        check("mthi_mtlo_lo", lo, 32'hA5A5_A5A5);

        @(negedge clk);
        wr_lo = 1'b1;
        wdata = 32'h1111_1111;
        launch(OP_MULTU, 32'h0001_0000, 32'h0001_0000, {32'd1, 32'd0});
        wr_lo = 1'b0;
        check("start_drops_write_lo", lo, 32'hA5A5_A5A5);
        wait_done("multu_2p32", -1, 32'd0, 32'd0);

`ifdef MULDIV_DIV_EN
        @(negedge clk);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_done("div_neg7_2", -1, 32'd0, 32'd0);
        @(negedge clk);
        launch(OP_DIVU, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF});
        wait_done("divu_by0", -1, 32'd0, 32'd0);
        @(negedge clk);
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        wait_done("div_overflow", -1, 32'd0, 32'd0);
        @(negedge clk);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        wait_done("div_by0_signed", -1, 32'd0, 32'd0);
        @(negedge clk);
        launch(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        wait_done("divu_100_7", -1, 32'd0, 32'd0);
        @(negedge clk);
        launch(OP_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
        wait_done("div_7_neg2", -1, 32'd0, 32'd0);
`else
        @(negedge clk);
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("divu_disabled_busy", {31'd0, busy_seen}, 32'd0);
        check("divu_disabled_hi", hi, 32'd1);
        check("divu_disabled_lo", lo, 32'd0);
`endif

        // Abort mid-operation with reset.
        @(negedge clk);
        op    = OP_MULTU;
        a     = 32'd7;
        b     = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_lo_after", lo, 32'd0);

        launch(OP_MULTU, 32'd3, 32'd4, {32'd0, 32'd12});
        wait_done("multu_after_abort", -1, 32'd0, 32'd0);

        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  launch request, sampled each edge.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand / dividend (rs).
REQ-007 b  input  32  multiplier / divisor (rt).
REQ-008 wr_hi  input  1  MTHI write strobe.
REQ-009 wr_lo  input  1  MTLO write strobe.
REQ-010 wdata  input  32  MTHI/MTLO data.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 hi  output  32  HI register, direct register output.
REQ-014 lo  output  32  LO register, direct register output.

Function
REQ-015 States SHALL be IDLE, RUN, FIN; busy SHALL be 1 in RUN and FIN, 0 in IDLE.
REQ-016 start=1 in IDLE SHALL latch op, a, b and enter RUN at that edge (E0).
REQ-017 RUN SHALL last exactly 32 cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-018 FIN SHALL last one cycle and apply sign correction; at the FIN-exit edge (E33) hi/lo SHALL be written, state SHALL return to IDLE, and done SHALL be 1 for exactly the following cycle.
REQ-019 Start-to-result latency SHALL therefore be 33 edges; a new start SHALL be accepted in the done cycle.
REQ-020 start while busy SHALL be ignored, latched operands unaffected.
REQ-021 MULT/MULTU: {hi,lo} = full 64-bit signed/unsigned product.
REQ-022 DIV/DIVU: lo = quotient, hi = remainder; signed: quotient truncates toward zero, remainder takes sign of a.
REQ-023 Divisor 0 (DIV and DIVU): lo = 0xFFFFFFFF, hi = a, still 33-edge latency.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-025 wr_hi/wr_lo in IDLE SHALL load wdata into hi/lo at next edge; both may assert together.
REQ-026 wr_hi/wr_lo while busy SHALL be ignored.
REQ-027 start and wr_hi/wr_lo same IDLE cycle: start SHALL be taken, write dropped.
REQ-028 hi/lo SHALL hold their values between operations and during RUN/FIN.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, internal accumulators cleared, overriding start and writes.
REQ-030 rst mid-operation SHALL abort with no done pulse and no hi/lo update from the aborted operation.

Configuration
REQ-031 Macro MULDIV_DIV_EN defined: divide datapath compiled in, DIV/DIVU per REQ-022..024.
REQ-032 MULDIV_DIV_EN undefined: no divide logic; start with op[1]=1 SHALL be ignored (stays IDLE, busy=0, no done, hi/lo unchanged); multiply unaffected.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at E33+1 cycle, hi=0xFFFFFFFE lo=0x00000001, busy high 33 cycles.
REQ-034 MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-035 DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=0x00000064; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-036 MULTU 7*6, second start (op=MULTU a=2 b=2) at cycle 5 of RUN -> ignored, result lo=42 hi=0.
REQ-037 Start MULTU 7*6, rst at cycle 10 -> busy=0, hi=lo=0, no done pulse in following 40 cycles.
REQ-038 IDLE wr_hi wdata=0x12345678 -> hi=0x12345678 next cycle; wr_lo during busy -> lo unchanged; MULTU 0x10000*0x10000 with MULTU-only build (macro undefined) then DIVU start -> DIVU ignored, hi=1 lo=0 retained.
